trigger_pattern_gen: RTL and testbench

Parametrised multi-channel trigger output generator that replaces free-running divider blinkers on the trigger outputs. Each channel independently produces a square wave, a periodic pulse of programmable width, or a single pulse. Every channel is configured through a single-cycle write port from the management logic. A global sync input realigns the phase of all running channels so that outputs on different connectors stay coherent.

---
 rtl/trigger_pattern_gen.sv | 139 +++++++++++++
 tb/tb_trigger_pattern_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_pattern_gen.sv
// trigger_pattern_gen: multi-channel trigger output generator.
// Each channel produces a square wave, a periodic pulse of programmable
// width, or a single pulse, and can be phase-realigned by a global sync.
module trigger_pattern_gen #(
   parameter int  CHANNELS    = 4,
   parameter int  COUNT_WIDTH = 24,
   localparam int ADDR_WIDTH  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_wr_en,
   input  logic [ADDR_WIDTH-1:0]  cfg_addr,
   input  logic [1:0]             cfg_mode,
   input  logic [COUNT_WIDTH-1:0] cfg_period,
   input  logic [COUNT_WIDTH-1:0] cfg_width,
   input  logic                   sync_in,
   output logic [CHANNELS-1:0]    trig_out,
   output logic [CHANNELS-1:0]    tick,
   output logic [CHANNELS-1:0]    active
);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_TOGGLE  = 2'd1,
      MODE_PULSE   = 2'd2,
      MODE_ONESHOT = 2'd3
   } mode_e;

   mode_e                  mode_q   [CHANNELS];
   mode_e                  mode_d   [CHANNELS];
   logic [COUNT_WIDTH-1:0] period_q [CHANNELS];
   logic [COUNT_WIDTH-1:0] period_d [CHANNELS];
   logic [COUNT_WIDTH-1:0] width_q  [CHANNELS];
   logic [COUNT_WIDTH-1:0] width_d  [CHANNELS];
   logic [COUNT_WIDTH-1:0] cnt_q    [CHANNELS];
   logic [COUNT_WIDTH-1:0] cnt_d    [CHANNELS];
   logic [COUNT_WIDTH-1:0] cnt_inc  [CHANNELS];
   logic [CHANNELS-1:0]    out_q, out_d;
   logic [CHANNELS-1:0]    tick_q, tick_d;
   logic [CHANNELS-1:0]    wr_hit;
   logic [CHANNELS-1:0]    wrap;

   // Per-channel decode: write address match, end-of-cycle and next count.
   // An out-of-range address simply matches no channel.
   always_comb begin
      wr_hit = '0;
      wrap   = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         wr_hit[c]  = cfg_wr_en && (cfg_addr == ADDR_WIDTH'(c));
         wrap[c]    = (cnt_q[c] == period_q[c]);
         cnt_inc[c] = wrap[c] ? '0 : cnt_q[c] + COUNT_WIDTH'(1);
      end
   end

   // Next-state logic: write beats sync, sync beats free-running count.
   always_comb begin
      // NOTE: every target gets a default first so no path leaves a latch.
      out_d  = out_q;
      tick_d = tick_q;
      for (int c = 0; c < CHANNELS; c++) begin
         mode_d[c]   = mode_q[c];
         period_d[c] = period_q[c];
         width_d[c]  = width_q[c];
         cnt_d[c]    = cnt_q[c];

         if (wr_hit[c]) begin
            mode_d[c]   = mode_e'(cfg_mode);
            period_d[c] = cfg_period;
            width_d[c]  = cfg_width;
            cnt_d[c]    = '0;
            tick_d[c]   = 1'b0;
            out_d[c]    = ((mode_e'(cfg_mode) == MODE_PULSE) ||
                           (mode_e'(cfg_mode) == MODE_ONESHOT)) &&
                          (cfg_width != '0);
         end else if (mode_q[c] == MODE_OFF) begin
            cnt_d[c]  = '0;
            out_d[c]  = 1'b0;
            tick_d[c] = 1'b0;
         end else if (sync_in) begin
            cnt_d[c]  = '0;
            tick_d[c] = 1'b0;
            out_d[c]  = (mode_q[c] != MODE_TOGGLE) && (width_q[c] != '0);
         end else begin
            cnt_d[c]  = cnt_inc[c];
            tick_d[c] = wrap[c];
            unique case (mode_q[c])
               MODE_TOGGLE:  out_d[c] = wrap[c] ? ~out_q[c] : out_q[c];
               MODE_PULSE:   out_d[c] = (cnt_inc[c] < width_q[c]);
               MODE_ONESHOT: begin
                  if (wrap[c]) begin
                     mode_d[c] = MODE_OFF;
                     out_d[c]  = 1'b0;
                  end else begin
                     out_d[c]  = (cnt_inc[c] < width_q[c]);
                  end
               end
               default:      out_d[c] = 1'b0;
            endcase
         end
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the small per-channel config arrays are flops, not RAM, so they are cleared with the rest.
         for (int c = 0; c < CHANNELS; c++) begin
            mode_q[c]   <= MODE_OFF;
            period_q[c] <= '0;
            width_q[c]  <= '0;
            cnt_q[c]    <= '0;
         end
         out_q  <= '0;
         tick_q <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
         for (int c = 0; c < CHANNELS; c++) begin
            mode_q[c]   <= mode_d[c];
            period_q[c] <= period_d[c];
            width_q[c]  <= width_d[c];
            cnt_q[c]    <= cnt_d[c];
         end
         out_q  <= out_d;
         tick_q <= tick_d;
      end
   end

   // Channel is active whenever its registered mode is not OFF.
   always_comb begin
      active = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         active[c] = (mode_q[c] != MODE_OFF);
      end
   end

   assign trig_out = out_q;
   assign tick     = tick_q;

endmodule

// File: tb/tb_trigger_pattern_gen.sv
// Testbench for trigger_pattern_gen: directed stimulus pushes expected
// per-channel outputs into a scoreboard queue; a monitor drains and compares.
module tb_trigger_pattern_gen;

   localparam int CH = 5;
   localparam int CW = 24;
   localparam int AW = (CH > 1) ? $clog2(CH) : 1;

   localparam logic [1:0] M_OFF     = 2'd0;
   localparam logic [1:0] M_TOGGLE  = 2'd1;
   localparam logic [1:0] M_PULSE   = 2'd2;
   localparam logic [1:0] M_ONESHOT = 2'd3;

   logic          clk;
   logic          rst;
   logic          cfg_wr_en;
   logic [AW-1:0] cfg_addr;
   logic [1:0]    cfg_mode;
   logic [CW-1:0] cfg_period;
   logic [CW-1:0] cfg_width;
   logic          sync_in;
   logic [CH-1:0] trig_out;
   logic [CH-1:0] tick;
   logic [CH-1:0] active;

   trigger_pattern_gen #(.CHANNELS(CH), .COUNT_WIDTH(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_wr_en  (cfg_wr_en),
      .cfg_addr   (cfg_addr),
      .cfg_mode   (cfg_mode),
      .cfg_period (cfg_period),
      .cfg_width  (cfg_width),
      .sync_in    (sync_in),
      .trig_out   (trig_out),
      .tick       (tick),
      .active     (active)
   );

   typedef struct {
      string         name;
      logic [CH-1:0] mask;
      logic [CH-1:0] trig;
      logic [CH-1:0] tck;
      logic [CH-1:0] act;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   event check_ev;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic ok);
      n_vec++;
      if (ok !== 1'b1) begin
         n_err++;
         $display("FAIL %s t=%0t trig=%b tick=%b act=%b", name, $time, trig_out, tick, active);
      end
   endtask

   // Monitor: drain every pending expectation on each falling edge (or on demand).
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or check_ev);
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("%s mask=%b exp trig=%b tick=%b act=%b", e.name, e.mask, e.trig, e.tck, e.act),
                  ((((trig_out ^ e.trig) | (tick ^ e.tck) | (active ^ e.act)) & e.mask) === '0));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic exp_ch(input string name, input int ch, input logic t, input logic k, input logic a);
      exp_t e;
      e.name = name;
      e.mask = '0; e.trig = '0; e.tck = '0; e.act = '0;
      e.mask[ch] = 1'b1;
      e.trig[ch] = t;
      e.tck[ch]  = k;
      e.act[ch]  = a;
      sb_q.push_back(e);
   endtask

   task automatic exp_all(input string name, input logic [CH-1:0] t, input logic [CH-1:0] k,
                          input logic [CH-1:0] a);
      exp_t e;
      e.name = name;
      e.mask = '1;
      e.trig = t;
      e.tck  = k;
      e.act  = a;
      sb_q.push_back(e);
   endtask

   // Advance one edge and drop the one-cycle strobes.
   task automatic step();
      @(posedge clk);
      #1;
      cfg_wr_en = 1'b0;
      sync_in   = 1'b0;
   endtask

   task automatic set_cfg(input int addr, input logic [1:0] mode, input int p, input int w);
      cfg_wr_en  = 1'b1;
      cfg_addr   = AW'(addr);
      cfg_mode   = mode;
      cfg_period = CW'(p);
      cfg_width  = CW'(w);
   endtask

   task automatic write_cfg(input int addr, input logic [1:0] mode, input int p, input int w);
      set_cfg(addr, mode, p, w);
      step();
   endtask

   initial begin
      rst = 1'b1; cfg_wr_en = 1'b0; cfg_addr = '0; cfg_mode = '0;
      cfg_period = '0; cfg_width = '0; sync_in = 1'b0;

      // Reset applied before any clock edge.
      #2;
      check("reset_async_trig", trig_out === '0);
      check("reset_async_tick", tick === '0);
      check("reset_async_act",  active === '0);
      exp_all("reset_async", '0, '0, '0);
      -> check_ev;
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 100; n++) begin
         step();
         exp_all("reset_idle", '0, '0, '0);
      end

      // TOGGLE ch0 P=3: period 8, tick every 4.
      write_cfg(0, M_TOGGLE, 3, 0);
      for (int n = 0; n < 24; n++) begin
         exp_ch("toggle", 0, ((n / 4) % 2) == 1, (n > 0) && (n % 4 == 0), 1'b1);
         step();
      end
      write_cfg(0, M_OFF, 0, 0);
      exp_ch("toggle_off", 0, 1'b0, 1'b0, 1'b0);

      // PULSE ch1 P=9 W=3.
      write_cfg(1, M_PULSE, 9, 3);
      for (int n = 0; n < 30; n++) begin
         exp_ch("pulse_w3", 1, (n % 10) < 3, (n > 0) && (n % 10 == 0), 1'b1);
         step();
      end
      // W=0: constant low.
      write_cfg(1, M_PULSE, 9, 0);
      for (int n = 0; n < 12; n++) begin
         exp_ch("pulse_w0", 1, 1'b0, n == 10, 1'b1);
         step();
      end
      // W>P: constant high, tick unaffected.
      write_cfg(1, M_PULSE, 9, 12);
      for (int n = 0; n < 22; n++) begin
         exp_ch("pulse_w12", 1, 1'b1, (n > 0) && (n % 10 == 0), 1'b1);
         step();
      end
      write_cfg(1, M_OFF, 0, 0);

      // ONESHOT ch2 P=5 W=2.
      write_cfg(2, M_ONESHOT, 5, 2);
      for (int n = 0; n < 16; n++) begin
         exp_ch("oneshot", 2, n < 2, n == 6, n < 6);
         step();
      end

      // Sync: start ch0 and ch1 at different times, then realign.
      write_cfg(0, M_TOGGLE, 7, 0);
      step(); step(); step();
      write_cfg(1, M_PULSE, 4, 2);
      step(); step();
      sync_in = 1'b1;
      step();
      for (int n = 0; n < 40; n++) begin
         exp_ch("sync_tog", 0, ((n / 8) % 2) == 1, (n > 0) && (n % 8 == 0), 1'b1);
         exp_ch("sync_pls", 1, (n % 5) < 2, (n > 0) && (n % 5 == 0), 1'b1);
         step();
      end

      // Write ch3 in the same cycle as sync; later an out-of-range write.
      set_cfg(3, M_PULSE, 2, 1);
      sync_in = 1'b1;
      step();
      for (int n = 0; n < 25; n++) begin
         exp_ch("coll_tog", 0, ((n / 8) % 2) == 1, (n > 0) && (n % 8 == 0), 1'b1);
         exp_ch("coll_pls", 1, (n % 5) < 2, (n > 0) && (n % 5 == 0), 1'b1);
         exp_ch("coll_ch3", 3, (n % 3) < 1, (n > 0) && (n % 3 == 0), 1'b1);
         exp_ch("idle_ch2", 2, 1'b0, 1'b0, 1'b0);
         exp_ch("idle_ch4", 4, 1'b0, 1'b0, 1'b0);
         if (n == 12) set_cfg(CH, M_TOGGLE, 1, 1);
         step();
      end

      // Reset mid-cycle clears outputs without a clock edge.
      #2;
      rst = 1'b1;
      #1;
      check("reset_mid_trig", trig_out === '0);
      check("reset_mid_tick", tick === '0);
      check("reset_mid_act",  active === '0);
      exp_all("reset_midcycle", '0, '0, '0);
      -> check_ev;
      step();
      exp_all("reset_held", '0, '0, '0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      step();
      check("after_reset_trig", trig_out === '0);
      check("after_reset_tick", tick === '0);
      check("after_reset_act",  active === '0);
      exp_all("after_reset", '0, '0, '0);
      @(negedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
